// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared FSM encoding, widths and index-wrap helper for the UART transmit scheduler.
package uart_sched_pkg;
   localparam int BYTE_W = 8;
   localparam int GID_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_FINISH    = 2'd3
   } state_t;

   function automatic int wrap(input int v, input int n);
      return (v >= n) ? v - n : v;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or after ptr.
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [GID_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [GID_W-1:0]   idx
);
   logic [NUM_REQ-1:0] rot;

   // rot[i] is requester (ptr+i) mod NUM_REQ; scanning downwards leaves the nearest one
   always_comb begin
      rot = NUM_REQ'({valid, valid} >> ptr);
      gnt = '0;
      idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (rot[i]) begin
            idx = GID_W'(wrap(int'(ptr) + i, NUM_REQ));
            gnt = NUM_REQ'(1) << idx;
         end
   end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin sharing of one UART transmitter between NUM_REQ requesters.
// Define UART_SCHED_TIMEOUT_EN to also bound the wait for uart_busy to fall by DONE_TMO cycles.
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ISSUE_TMO = 16,
   parameter int DONE_TMO  = 'h00FF_FFFF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [NUM_REQ-1:0]        req_done,
   output logic                      req_err,
   output logic [GID_W-1:0]          grant_id,
   output logic                      tx_external,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      uart_busy,
   output logic                      sched_busy
);
   localparam int MAX_TMO = (ISSUE_TMO > DONE_TMO) ? ISSUE_TMO : DONE_TMO;
   localparam int CNT_W   = $clog2(MAX_TMO + 1);

   state_t             state;
   logic [GID_W-1:0]   rr_ptr;
   logic [GID_W-1:0]   arb_idx;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [CNT_W-1:0]   cnt;
   logic               err;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .valid (req_valid),
      .ptr   (rr_ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx)
   );

   assign sched_busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         tx_external <= 1'b0;
         tx_data     <= '0;
         req_ack     <= '0;
         req_done    <= '0;
         req_err     <= 1'b0;
         cnt         <= '0;
         err         <= 1'b0;
      end else begin
         req_ack  <= '0;
         req_done <= '0;
         req_err  <= 1'b0;
         case (state)
            ST_IDLE:
               if (|req_valid && !uart_busy) begin
                  tx_data     <= BYTE_W'(req_data >> {arb_idx, 3'b000});
                  grant_id    <= arb_idx;
                  req_ack     <= arb_gnt;
                  tx_external <= 1'b1;
                  cnt         <= '0;
                  state       <= ST_ISSUE;
               end
            ST_ISSUE:
               if (uart_busy) begin
                  tx_external <= 1'b0;
                  cnt         <= '0;
                  state       <= ST_WAIT_DONE;
               end else if (cnt == CNT_W'(ISSUE_TMO - 1)) begin
                  tx_external <= 1'b0;
                  err         <= 1'b1;
                  cnt         <= '0;
                  state       <= ST_FINISH;
               end else
                  cnt <= cnt + CNT_W'(1);
`ifdef UART_SCHED_TIMEOUT_EN
            // a byte that completes on the deadline cycle still counts as good
            ST_WAIT_DONE:
               if (!uart_busy || cnt == CNT_W'(DONE_TMO - 1)) begin
                  err   <= uart_busy;
                  cnt   <= '0;
                  state <= ST_FINISH;
               end else
                  cnt <= cnt + CNT_W'(1);
`else
            ST_WAIT_DONE:
               if (!uart_busy) begin
                  cnt   <= '0;
                  state <= ST_FINISH;
               end
`endif
            ST_FINISH: begin
               req_done <= NUM_REQ'(1) << grant_id;
               req_err  <= err;
               err      <= 1'b0;
               rr_ptr   <= GID_W'(wrap(int'(grant_id) + 1, NUM_REQ));
               cnt      <= '0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized checks of uart_tx_sched against a cycle-level reference model.
// Build with UART_SCHED_TIMEOUT_EN to exercise the completion timeout with DONE_TMO=100.
module tb_uart_tx_sched;
   localparam int N    = 4;
   localparam int ITMO = 16;
`ifdef UART_SCHED_TIMEOUT_EN
   localparam int DTMO = 100;
`else
   localparam int DTMO = 'h00FF_FFFF;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic           uart_busy = 1'b0;
   logic [N-1:0]   req_ack, req_done;
   logic           req_err, tx_external, sched_busy;
   logic [2:0]     grant_id;
   logic [7:0]     tx_data;

   uart_tx_sched #(.NUM_REQ(N), .ISSUE_TMO(ITMO), .DONE_TMO(DTMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ack     (req_ack),
      .req_done    (req_done),
      .req_err     (req_err),
      .grant_id    (grant_id),
      .tx_external (tx_external),
      .tx_data     (tx_data),
      .uart_busy   (uart_busy),
      .sched_busy  (sched_busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // inputs as the DUT saw them on the last rising edge
   logic [N-1:0]   s_valid;
   logic [8*N-1:0] s_data;
   logic           s_busy, s_rst;
   always @(posedge clk) begin
      s_valid <= req_valid;
      s_data  <= req_data;
      s_busy  <= uart_busy;
      s_rst   <= reset;
   end

   // reference: who is owed service, how long the strobe has been up, whether the byte is finished
   bit m_act, m_rose, m_fin, m_err;
   int m_age, m_ptr, m_gid;
   int e_ack, e_done, e_err, e_tx, e_gid, e_data, e_sb;

   function automatic void model_step();
      e_ack = 0; e_done = 0; e_err = 0;
      if (!reset || !s_rst) begin
         m_act = 0; m_rose = 0; m_fin = 0; m_err = 0; m_age = 0; m_ptr = 0; m_gid = 0;
         e_tx = 0; e_gid = 0; e_data = 0;
      end else if (m_fin) begin
         e_done = 1 << m_gid; e_err = int'(m_err);
         m_err = 0; m_fin = 0; m_act = 0;
         m_ptr = (m_gid + 1) % N;
      end else if (!m_act) begin
         if (s_valid != 0 && !s_busy) begin
            for (int i = 0; i < N; i++)
               if (((int'(s_valid) >> ((m_ptr + i) % N)) % 2) == 1) begin
                  m_gid = (m_ptr + i) % N;
                  break;
               end
            e_gid = m_gid; e_data = int'(s_data >> (8 * m_gid)) & 255; e_ack = 1 << m_gid;
            e_tx = 1; m_act = 1; m_rose = 0; m_age = 1;
         end
      end else if (!m_rose) begin
         if (s_busy) begin m_rose = 1; m_age = 0; e_tx = 0; end
         else if (m_age == ITMO) begin e_tx = 0; m_err = 1; m_fin = 1; end
         else m_age++;
      end else begin
         m_age++;
         if (!s_busy) m_fin = 1;
`ifdef UART_SCHED_TIMEOUT_EN
         else if (m_age == DTMO) begin m_fin = 1; m_err = 1; end
`endif
      end
      e_sb = int'(m_act);
   endfunction

   always @(negedge clk) begin
      model_step();
      chk("req_ack", int'(req_ack), e_ack);
      chk("req_done", int'(req_done), e_done);
      chk("req_err", int'(req_err), e_err);
      chk("tx_external", int'(tx_external), e_tx);
      chk("grant_id", int'(grant_id), e_gid);
      chk("tx_data", int'(tx_data), e_data);
      chk("sched_busy", int'(sched_busy), e_sb);
   end

   // transmitter stand-in: busy rises rise_dly cycles after the strobe, holds hold_len cycles
   int x_wait = 0, x_hold = 0, rise_dly = 1, hold_len = 5;
   bit never_rise = 0, stuck = 0, rnd_mode = 0, x_ign = 0;
   always @(negedge clk) begin
      if (!reset) begin
         x_wait = 0; x_hold = 0; x_ign = 0;
         if (!stuck) uart_busy = 1'b0;
      end else if (x_hold > 0) begin
         x_hold--;
         if (x_hold == 0 && !stuck) uart_busy = 1'b0;
      end else if (x_wait > 0) begin
         x_wait--;
         if (x_wait == 0) begin uart_busy = 1'b1; x_hold = hold_len; end
      end else if (!tx_external) x_ign = 0;
      else if (!x_ign && !uart_busy) begin
         if (rnd_mode) begin
            rise_dly   = $urandom_range(1, 3);
            hold_len   = $urandom_range(1, 20);
            never_rise = ($urandom_range(0, 9) == 0);
         end
         if (never_rise) x_ign = 1; else x_wait = rise_dly;
      end
   end

   task automatic wait_ev(input string nm, input bit done_ev, input int budget);
      bit ok = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (done_ev ? |req_done : |req_ack) begin ok = 1; break; end
      end
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL %s: no event within %0d cycles", nm, budget);
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #2 reset = 1'b0; #1;
      chk("rst_tx_external", int'(tx_external), 0);
      chk("rst_req_ack", int'(req_ack), 0);
      chk("rst_req_done", int'(req_done), 0);
      chk("rst_sched_busy", int'(sched_busy), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      @(negedge clk); #2 reset = 1'b1;
   endtask

   initial begin
      int hi, acks;
      repeat (3) @(negedge clk);
      chk("init_sched_busy", int'(sched_busy), 0);
      chk("init_tx_external", int'(tx_external), 0);
      #2 reset = 1'b1;
      // single request, long transmission
      @(negedge clk);
      hold_len = 200; req_data[15:8] = 8'hA5; req_valid = 4'b0010;
      wait_ev("t1_ack", 0, 20);
      chk("t1_grant", int'(grant_id), 1);
      chk("t1_data", int'(tx_data), 'hA5);
      chk("t1_ack", int'(req_ack), 'b0010);
      req_valid = '0;
      wait_ev("t1_done", 1, 400);
      chk("t1_done", int'(req_done), 'b0010);
      chk("t1_err", int'(req_err), 0);
      // all valid: strict rotation from 0
      do_reset();
      hold_len = 5; req_data = 32'h4433_2211; req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         wait_ev("t2_ack", 0, 60);
         chk("t2_order", int'(grant_id), k % 4);
      end
      req_valid = '0;
      wait_ev("t2_done", 1, 60);
      // transmitter never answers: issue timeout, then the next requester
      do_reset();
      never_rise = 1; req_valid = 4'b1100;
      wait_ev("t3_ack", 0, 20);
      chk("t3_grant", int'(grant_id), 2);
      req_valid[2] = 1'b0;
      hi = 0;
      for (int c = 0; c < 40; c++) begin
         if (!tx_external) break;
         hi++;
         @(negedge clk);
      end
      chk("t3_strobe_len", hi, ITMO);
      wait_ev("t3_done", 1, 10);
      chk("t3_done", int'(req_done), 'b0100);
      chk("t3_err", int'(req_err), 1);
      wait_ev("t3_next", 0, 10);
      chk("t3_next_grant", int'(grant_id), 3);
      req_valid = '0;
      wait_ev("t3_done2", 1, 40);
      never_rise = 0;
      // reset while waiting for the transmitter
      do_reset();
      hold_len = 50; req_valid = 4'b0010;
      wait_ev("t4_ack", 0, 20);
      for (int c = 0; c < 10 && !uart_busy; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("t4_in_wait", int'(sched_busy), 1);
      do_reset();
      wait_ev("t4_reserve", 0, 20);
      chk("t4_grant", int'(grant_id), 1);
      req_valid = '0;
      wait_ev("t4_done", 1, 100);
      // wrap of the round-robin pointer
      do_reset();
      hold_len = 3; req_valid = 4'b1000;
      wait_ev("t6_ack3", 0, 20);
      chk("t6_first", int'(grant_id), 3);
      req_valid = 4'b1001;
      wait_ev("t6_ack0", 0, 40);
      chk("t6_wrap", int'(grant_id), 0);
      req_valid = 4'b1000;
      wait_ev("t6_ack3b", 0, 40);
      chk("t6_back", int'(grant_id), 3);
      req_valid = '0;
      wait_ev("t6_done", 1, 40);
`ifdef UART_SCHED_TIMEOUT_EN
      // transmitter stuck busy: completion timeout, then hold-off until it frees
      do_reset();
      stuck = 1; req_valid = 4'b0010;
      wait_ev("t5_ack", 0, 20);
      req_valid = 4'b0100;
      wait_ev("t5_done", 1, DTMO + 20);
      chk("t5_done", int'(req_done), 'b0010);
      chk("t5_err", int'(req_err), 1);
      acks = 0;
      repeat (20) begin @(negedge clk); if (|req_ack) acks++; end
      chk("t5_hold_off", acks, 0);
      stuck = 0; uart_busy = 1'b0;
      wait_ev("t5_regrant", 0, 20);
      chk("t5_grant", int'(grant_id), 2);
      req_valid = '0;
      wait_ev("t5_done2", 1, 60);
`endif
      // randomized traffic
      do_reset();
      rnd_mode = 1;
      repeat (4000) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (req_ack[i]) begin
               if ($urandom_range(0, 1) == 1) req_data[8*i +: 8] = 8'($urandom);
               else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
               req_valid[i] = 1'b1;
               req_data[8*i +: 8] = 8'($urandom);
            end
      end
      req_valid = '0;
      for (int c = 0; c < 300 && (sched_busy || uart_busy); c++) @(negedge clk);
      chk("drain_idle", int'(sched_busy), 0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #600000;
      miscompares++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
